// File: rtl/pcache_flush_ctrl.sv
// Pixel cache flush controller: one cached 8-pixel row, read-modify-write of every plane on flush.
// Optional macro PCACHE_RMW_SKIP_EN: a flush of a full row (bpr==8'hFF) writes each plane without reading it.
module pcache_flush_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        plot_req,
   input  logic [2:0]  plot_x,
   input  logic [15:0] plot_tile,
   input  logic        flush_req,
   input  logic [1:0]  mode,
   input  logic        ram_ack,
   output logic        plot_ack,
   output logic        ldpix,
   output logic [2:0]  pixel_sel,
   output logic [7:0]  bpr,
   output logic [2:0]  plane_sel,
   output logic        ramdone,
   output logic        ram_rd_req,
   output logic        ram_wr_req,
   output logic [2:0]  ram_plane,
   output logic [15:0] ram_tile,
   output logic        busy,
   output logic        flush_done
);

   // state | meaning
   // IDLE  | wait for plot, flush request or full row
   // PLOT  | accept plot, mark column pending
   // READ  | read plane p from RAM, merge under bpr
   // WRITE | write plane p back to RAM
   // DONE  | clear bpr, pulse flush_done
   typedef enum logic [2:0] {
      S_IDLE,
      S_PLOT,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  bpr_q, bpr_d;
   logic [15:0] ram_tile_q, ram_tile_d;
   logic [2:0]  p_q, p_d;
   logic [2:0]  last_q, last_d;
   logic        skip_q, skip_d;
   logic        start_flush;
   logic        skip_start;
   logic        plot_hit;
   logic [2:0]  last_mode;

`ifdef PCACHE_RMW_SKIP_EN
   assign skip_start = (bpr_q == 8'hFF);
`else
   assign skip_start = 1'b0;
`endif

   assign plot_hit = (bpr_q == 8'h00) || (plot_tile == ram_tile_q);

   always_comb begin
      last_mode = 3'd3;
      case (mode)
         2'b00:   last_mode = 3'd1;
         2'b01:   last_mode = 3'd3;
         2'b10:   last_mode = 3'd3;
         2'b11:   last_mode = 3'd7;
         default: last_mode = 3'd3;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         bpr_q      <= 8'h00;
         ram_tile_q <= 16'h0000;
         p_q        <= 3'd0;
         last_q     <= 3'd0;
         skip_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bpr_q      <= bpr_d;
         ram_tile_q <= ram_tile_d;
         p_q        <= p_d;
         last_q     <= last_d;
         skip_q     <= skip_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bpr_d       = bpr_q;
      ram_tile_d  = ram_tile_q;
      p_d         = p_q;
      last_d      = last_q;
      skip_d      = skip_q;
      start_flush = 1'b0;
      plot_ack    = 1'b0;
      ldpix       = 1'b0;
      pixel_sel   = 3'd0;
      plane_sel   = 3'd0;
      ramdone     = 1'b0;
      ram_rd_req  = 1'b0;
      ram_wr_req  = 1'b0;
      flush_done  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // flush_req outranks plot_req; an empty row flushes with no RAM traffic
            if (flush_req) begin
               if (bpr_q != 8'h00) start_flush = 1'b1;
               else                state_d     = S_DONE;
            end else if (bpr_q == 8'hFF) begin
               start_flush = 1'b1;
            end else if (plot_req) begin
               if (plot_hit) state_d     = S_PLOT;
               else          start_flush = 1'b1;
            end
            if (start_flush) begin
               p_d     = 3'd0;
               last_d  = last_mode;
               skip_d  = skip_start;
               state_d = skip_start ? S_WRITE : S_READ;
            end
         end
         S_PLOT: begin
            plot_ack   = 1'b1;
            ldpix      = 1'b1;
            pixel_sel  = plot_x;
            bpr_d      = bpr_q | (8'h01 << plot_x);
            ram_tile_d = plot_tile;
            state_d    = S_IDLE;
         end
         S_READ: begin
            ram_rd_req = 1'b1;
            plane_sel  = p_q;
            if (ram_ack) begin
               ramdone = 1'b1;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            ram_wr_req = 1'b1;
            plane_sel  = p_q;
            if (ram_ack) begin
               if (p_q == last_q) begin
                  state_d = S_DONE;
               end else begin
                  p_d     = p_q + 3'd1;
                  state_d = skip_q ? S_WRITE : S_READ;
               end
            end
         end
         S_DONE: begin
            flush_done = 1'b1;
            bpr_d      = 8'h00;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bpr       = bpr_q;
   assign ram_tile  = ram_tile_q;
   assign ram_plane = plane_sel;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pcache_flush_ctrl.sv
// Directed bench for pcache_flush_ctrl: plots, explicit and automatic flushes, reset mid-flush.
// A RAM responder acks each request in its third cycle; a monitor logs completed transfers.
module tb_pcache_flush_ctrl;

   logic        clk;
   logic        reset;
   logic        plot_req;
   logic [2:0]  plot_x;
   logic [15:0] plot_tile;
   logic        flush_req;
   logic [1:0]  mode;
   logic        ram_ack;
   logic        plot_ack;
   logic        ldpix;
   logic [2:0]  pixel_sel;
   logic [7:0]  bpr;
   logic [2:0]  plane_sel;
   logic        ramdone;
   logic        ram_rd_req;
   logic        ram_wr_req;
   logic [2:0]  ram_plane;
   logic [15:0] ram_tile;
   logic        busy;
   logic        flush_done;

   int checks;
   int failures;

   int viol, rd_cycles, req_cycles, done_cnt, rdn_cnt;
   logic prev_rd, prev_wr, prev_ack;
   int log_q[$];
   int exp_log[$];
   int rsp_cnt;

   pcache_flush_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .plot_req   (plot_req),
      .plot_x     (plot_x),
      .plot_tile  (plot_tile),
      .flush_req  (flush_req),
      .mode       (mode),
      .ram_ack    (ram_ack),
      .plot_ack   (plot_ack),
      .ldpix      (ldpix),
      .pixel_sel  (pixel_sel),
      .bpr        (bpr),
      .plane_sel  (plane_sel),
      .ramdone    (ramdone),
      .ram_rd_req (ram_rd_req),
      .ram_wr_req (ram_wr_req),
      .ram_plane  (ram_plane),
      .ram_tile   (ram_tile),
      .busy       (busy),
      .flush_done (flush_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      ram_ack = 1'b0;
      rsp_cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (ram_ack) begin
            ram_ack = 1'b0;
            rsp_cnt = 0;
         end
         if (ram_rd_req || ram_wr_req) begin
            rsp_cnt = rsp_cnt + 1;
            if (rsp_cnt == 3) ram_ack = 1'b1;
         end else begin
            rsp_cnt = 0;
         end
      end
   end

   // log codes: 16+p read ack, 32+p write ack, 64 flush_done
   always @(negedge clk) begin
      if (reset) begin
         prev_rd  <= 1'b0;
         prev_wr  <= 1'b0;
         prev_ack <= 1'b0;
      end else begin
         viol <= viol + int'(ram_rd_req && ram_wr_req)
                      + int'(ramdone != (ram_rd_req && ram_ack))
                      + int'(ram_plane != plane_sel)
                      + int'(prev_rd && !prev_ack && !ram_rd_req)
                      + int'(prev_wr && !prev_ack && !ram_wr_req);
         rd_cycles  <= rd_cycles + int'(ram_rd_req);
         req_cycles <= req_cycles + int'(ram_rd_req || ram_wr_req);
         rdn_cnt    <= rdn_cnt + int'(ramdone);
         done_cnt   <= done_cnt + int'(flush_done);
         if (ram_rd_req && ram_ack) log_q.push_back(16 + int'(ram_plane));
         if (ram_wr_req && ram_ack) log_q.push_back(32 + int'(ram_plane));
         if (flush_done) log_q.push_back(64);
         prev_rd  <= ram_rd_req;
         prev_wr  <= ram_wr_req;
         prev_ack <= ram_ack;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic chk_log(input string tag, input int base);
      int got;
      chk({tag, "_len"}, log_q.size() - base, exp_log.size());
      for (int k = 0; k < exp_log.size(); k++) begin
         got = (base + k < log_q.size()) ? log_q[base + k] : -1;
         chk($sformatf("%s_%0d", tag, k), got, exp_log[k]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic do_plot(input logic [2:0] x, input logic [15:0] tile, output int lat);
      logic       ld;
      logic [2:0] ps;
      ld  = 1'b0;
      ps  = 3'd0;
      lat = -1;
      @(posedge clk);
      #1;
      plot_req  = 1'b1;
      plot_x    = x;
      plot_tile = tile;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (plot_ack) begin
            lat = i;
            ld  = ldpix;
            ps  = pixel_sel;
            break;
         end
      end
      if (lat >= 0) begin
         chk("plot_ldpix", ld, 1);
         chk("plot_pixel_sel", ps, x);
      end else begin
         chk("plot_ack_timeout", 0, 1);
      end
      @(posedge clk);
      #1 plot_req = 1'b0;
   endtask

   task automatic do_flush(output int lat);
      lat = -1;
      @(posedge clk);
      #1 flush_req = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (flush_done) begin
            lat = i;
            break;
         end
         @(posedge clk);
         #1 flush_req = 1'b0;
      end
      flush_req = 1'b0;
      if (lat < 0) chk("flush_done_timeout", 0, 1);
   endtask

   task automatic wait_done(input logic perturb, output int lat);
      lat = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (perturb && (ram_rd_req || ram_wr_req)) mode = 2'b11;
         if (flush_done) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) chk("auto_flush_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, base, d0, rq0, rd0, rdn0;
      logic found;
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      plot_req  = 1'b0;
      plot_x    = 3'd0;
      plot_tile = 16'h0000;
      flush_req = 1'b0;
      mode      = 2'b00;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_ctrl", {plot_ack, ldpix, ramdone, ram_rd_req, ram_wr_req, busy, flush_done}, 0);
      chk("rst_bpr", bpr, 0);
      chk("rst_tile", ram_tile, 0);
      chk("rst_sel", {plane_sel, pixel_sel, ram_plane}, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // single plot from reset
      do_plot(3'd3, 16'h0040, lat);
      chk("plot_lat", lat, 1);
      @(negedge clk);
      chk("plot_bpr", bpr, 8'h08);
      chk("plot_tile", ram_tile, 16'h0040);
      chk("plot_idle", busy, 0);

      // explicit flush, 2 planes
      do_reset();
      do_plot(3'd0, 16'h0040, lat);
      chk("p0_lat", lat, 1);
      mode = 2'b00;
      base = log_q.size();
      rdn0 = rdn_cnt;
      do_flush(lat);
      chk("flush2_lat", lat, 13);
      #1;
      exp_log = '{16, 32, 17, 33, 64};
      chk_log("flush2_seq", base);
      chk("flush2_ramdone", rdn_cnt - rdn0, 2);
      @(negedge clk);
      chk("flush2_bpr", bpr, 0);

      // flush of an empty row
      rq0 = req_cycles;
      do_flush(lat);
      chk("empty_flush_lat", lat, 1);
      #1 chk("empty_flush_noram", req_cycles - rq0, 0);

      // flush_req outranks plot_req
      @(posedge clk);
      #1;
      flush_req = 1'b1;
      plot_req  = 1'b1;
      plot_x    = 3'd7;
      plot_tile = 16'h0040;
      @(posedge clk);
      #1 flush_req = 1'b0;
      @(negedge clk);
      chk("prio_done", {flush_done, plot_ack}, 2'b10);
      @(negedge clk);
      chk("prio_idle_noack", plot_ack, 0);
      @(negedge clk);
      chk("prio_plot_ack", plot_ack, 1);
      @(posedge clk);
      #1 plot_req = 1'b0;
      @(negedge clk);
      chk("prio_bpr", bpr, 8'h80);

      // tile miss forces a flush before the plot
      do_reset();
      mode = 2'b00;
      do_plot(3'd2, 16'h0010, lat);
      @(negedge clk);
      chk("miss_pre_bpr", bpr, 8'h04);
      d0 = done_cnt;
      do_plot(3'd5, 16'h0011, lat);
      chk("miss_lat", lat, 15);
      chk("miss_flushed", done_cnt - d0, 1);
      @(negedge clk);
      chk("miss_bpr", bpr, 8'h20);
      chk("miss_tile", ram_tile, 16'h0011);

      // full row auto flush, 4 planes, mode change mid-flush ignored
      do_reset();
      mode = 2'b01;
      base = log_q.size();
      for (int x = 0; x < 8; x++) begin
         do_plot(3'(x), 16'h0055, lat);
         chk($sformatf("full_plot%0d_lat", x), lat, 1);
      end
      rd0 = rd_cycles;
      wait_done(1'b1, lat);
      #1;
`ifdef PCACHE_RMW_SKIP_EN
      exp_log = '{32, 33, 34, 35, 64};
      chk("full_rd_cycles", rd_cycles - rd0, 0);
`else
      exp_log = '{16, 32, 17, 33, 18, 34, 19, 35, 64};
      chk("full_rd_cycles", rd_cycles - rd0, 12);
`endif
      chk_log("full_seq", base);
      mode = 2'b00;
      @(negedge clk);
      chk("full_bpr", bpr, 0);

      // reset during write of plane 2
      do_reset();
      mode = 2'b11;
      do_plot(3'd1, 16'h0020, lat);
      chk("abort_plot_lat", lat, 1);
      d0 = done_cnt;
      @(posedge clk);
      #1 flush_req = 1'b1;
      @(posedge clk);
      #1 flush_req = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (ram_wr_req && ram_plane == 3'd2) begin
            found = 1'b1;
            break;
         end
      end
      chk("abort_reached_wr2", found, 1);
      #1 reset = 1'b1;
      #1;
      chk("abort_async_drop", {ram_rd_req, ram_wr_req, busy}, 0);
      chk("abort_bpr", bpr, 0);
      chk("abort_plane", plane_sel, 0);
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
      rq0 = req_cycles;
      repeat (10) @(negedge clk);
      #1;
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_no_req", req_cycles - rq0, 0);
      do_plot(3'd6, 16'h0030, lat);
      chk("abort_next_lat", lat, 1);
      @(negedge clk);
      chk("abort_next_bpr", bpr, 8'h40);
      chk("abort_next_tile", ram_tile, 16'h0030);

      #1 chk("protocol_violations", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
